// File: rtl/irq_claim_arbiter.sv
// irq_claim_arbiter
//   Interrupt gateway and claim/complete arbiter. Each source runs a small
//   IDLE -> PENDING -> IN_SERVICE gateway. Among pending sources whose
//   priority is above the threshold, the highest priority wins, and ties go
//   to the lowest index. The winner is registered every cycle. A CPU claim
//   hands out that registered ID and moves the source to IN_SERVICE. A
//   completion returns the source to IDLE.
//
// Ports
//   clk             single clock, all logic on posedge
//   rst_n           synchronous active-low reset
//   irq_pend_i      per-source level pending (already masked upstream)
//   prio_i          per-source priority, source i at [i*PRIO_WIDTH +: PRIO_WIDTH]
//   threshold_i     only priorities strictly greater are delivered
//   claim_req_i     one-cycle claim strobe
//   claim_valid_o   one-cycle strobe, one cycle after each claim_req_i
//   claim_id_o      claimed ID (source i -> i+1), 0 if nothing claimable
//   complete_req_i  one-cycle completion strobe
//   complete_id_i   ID being completed
//   complete_err_o  one-cycle strobe: the completion was ignored
//   irq_o           interrupt request to the core (registered winner valid)
//   in_service_o    per-source IN_SERVICE flags
module irq_claim_arbiter #(
  parameter int NUM_IRQS   = 32,
  parameter int PRIO_WIDTH = 3,
  localparam int ID_WIDTH  = $clog2(NUM_IRQS + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IRQS-1:0]            irq_pend_i,
  input  logic [NUM_IRQS*PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]          threshold_i,
  input  logic                           claim_req_i,
  output logic                           claim_valid_o,
  output logic [ID_WIDTH-1:0]            claim_id_o,
  input  logic                           complete_req_i,
  input  logic [ID_WIDTH-1:0]            complete_id_i,
  output logic                           complete_err_o,
  output logic                           irq_o,
  output logic [NUM_IRQS-1:0]            in_service_o
);

  typedef enum logic [1:0] {
    GW_IDLE       = 2'd0,
    GW_PENDING    = 2'd1,
    GW_IN_SERVICE = 2'd2
  } gw_state_t;

  gw_state_t             gw_state [NUM_IRQS];
  gw_state_t             gw_next  [NUM_IRQS];

  logic                  best_valid;
  logic [ID_WIDTH-1:0]   best_id;

  logic                  arb_valid;
  logic [ID_WIDTH-1:0]   arb_id;
  logic [PRIO_WIDTH-1:0] arb_prio;

  logic                  claim_hit;
  logic                  claim_accept;
  logic                  cpl_hit;
  logic                  cpl_accept;

  // Arbitration over the current gateway state. A priority of 0 can never
  // exceed the threshold, so it is never delivered. The strict '>' on the
  // running best keeps the lowest index on a tie.
  always_comb begin
    arb_valid = 1'b0;
    arb_id    = '0;
    arb_prio  = '0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      if (gw_state[i] == GW_PENDING &&
          prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > threshold_i) begin
        if (!arb_valid || prio_i[i*PRIO_WIDTH +: PRIO_WIDTH] > arb_prio) begin
          arb_valid = 1'b1;
          arb_id    = ID_WIDTH'(i + 1);
          arb_prio  = prio_i[i*PRIO_WIDTH +: PRIO_WIDTH];
        end
      end
    end
  end

  // A claim is honoured only if the registered winner is still PENDING.
  // The registered winner can be one cycle stale right after it was
  // claimed, so this check is what prevents handing out a duplicate ID.
  // IDs of 0 or above NUM_IRQS match no source, so they fall out as
  // not-hit naturally.
  always_comb begin
    claim_hit = 1'b0;
    cpl_hit   = 1'b0;
    for (int i = 0; i < NUM_IRQS; i++) begin
      if (best_id == ID_WIDTH'(i + 1) && gw_state[i] == GW_PENDING)
        claim_hit = 1'b1;
      if (complete_id_i == ID_WIDTH'(i + 1) && gw_state[i] == GW_IN_SERVICE)
        cpl_hit = 1'b1;
    end
    claim_accept = claim_req_i & best_valid & claim_hit;
    cpl_accept   = complete_req_i & cpl_hit;
  end

  // Gateway next state. Claim and completion both look at the current
  // state. A completion aimed at a source that is being claimed this
  // cycle therefore sees it as PENDING and is rejected.
  always_comb begin
    for (int i = 0; i < NUM_IRQS; i++) begin
      gw_next[i] = gw_state[i];
      case (gw_state[i])
        GW_IDLE:
          if (irq_pend_i[i]) gw_next[i] = GW_PENDING;
        GW_PENDING:
          if (claim_accept && best_id == ID_WIDTH'(i + 1))
            gw_next[i] = GW_IN_SERVICE;
        GW_IN_SERVICE:
          if (cpl_accept && complete_id_i == ID_WIDTH'(i + 1))
            gw_next[i] = GW_IDLE;
        default:
          gw_next[i] = GW_IDLE;
      endcase
    end
  end

  // State register: gateways, registered winner and response strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IRQS; i++) gw_state[i] <= GW_IDLE;
      best_valid     <= 1'b0;
      best_id        <= '0;
      claim_valid_o  <= 1'b0;
      claim_id_o     <= '0;
      complete_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IRQS; i++) gw_state[i] <= gw_next[i];
      best_valid     <= arb_valid;
      best_id        <= arb_id;
      claim_valid_o  <= claim_req_i;
      if (claim_req_i)
        claim_id_o   <= claim_accept ? best_id : '0;
      complete_err_o <= complete_req_i & ~cpl_hit;
    end
  end

  // Outputs
  always_comb begin
    irq_o = best_valid;
    for (int i = 0; i < NUM_IRQS; i++)
      in_service_o[i] = (gw_state[i] == GW_IN_SERVICE);
  end

endmodule
